// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory behind the control unit's
// memory port. Accepts one load/store at a time over a valid/ready request
// channel, performs byte/half/word accesses with RISC-V funct3 semantics,
// and returns the result after LATENCY wait cycles on a valid/ready
// response channel.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // funct3 encodings understood by the responder
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wait counter only needs to hold LATENCY-1; keep at least one bit so
    // the declaration stays legal when LATENCY is 0 or 1.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Result captured at the accept edge, presented when RESP is entered.
    logic [31:0] pend_rdata;
    logic        pend_err;

    // Storage: word-addressed, written a byte lane at a time.
    logic [31:0] mem [DEPTH_WORDS];

    // Decoded view of the request currently on the inputs.
    logic [IDX_W-1:0] acc_idx;
    logic [1:0]       lane;
    logic             funct3_ok;
    logic             aligned;
    logic             acc_err;
    logic [3:0]       acc_be;
    logic [31:0]      acc_wlanes;
    logic             accept;
    logic             mem_we;

    // Load formatting signals.
    logic [31:0] rd_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] acc_rdata;

    // A request is taken only in IDLE with ready raised, and never while
    // reset is held, so a store can't slip into the array during reset.
    assign accept = req_valid && req_ready && (state == ST_IDLE) && !reset;
    assign mem_we = accept && req_write && !acc_err;

    // Decode size, alignment, legality and byte-lane write enables.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        acc_idx    = req_addr[IDX_W+1:2];
        lane       = req_addr[1:0];
        funct3_ok  = 1'b1;
        aligned    = 1'b1;
        acc_be     = 4'b0000;
        acc_wlanes = 32'h0000_0000;
        case (req_funct3)
            F3_B: begin
                acc_be     = 4'b0001 << lane;
                acc_wlanes = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                aligned    = ~lane[0];
                acc_be     = lane[1] ? 4'b1100 : 4'b0011;
                acc_wlanes = {2{req_wdata[15:0]}};
            end
            F3_W: begin
                aligned    = (lane == 2'b00);
                acc_be     = 4'b1111;
                acc_wlanes = req_wdata;
            end
            F3_BU: begin
                // Unsigned variants only make sense for loads.
                funct3_ok = ~req_write;
            end
            F3_HU: begin
                funct3_ok = ~req_write;
                aligned   = ~lane[0];
            end
            default: begin
                funct3_ok = 1'b0;
            end
        endcase
        acc_err = ~funct3_ok | ~aligned;
    end

    // Select the addressed lane(s) of the stored word and extend them.
    always_comb begin
        rd_word   = mem[acc_idx];
        byte_sel  = 8'h00;
        half_sel  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        acc_rdata = 32'h0000_0000;
        case (lane)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        case (req_funct3)
            F3_B:    acc_rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    acc_rdata = {{16{half_sel[15]}}, half_sel};
            F3_W:    acc_rdata = rd_word;
            F3_BU:   acc_rdata = {24'h00_0000, byte_sel};
            F3_HU:   acc_rdata = {16'h0000, half_sel};
            default: acc_rdata = 32'h0000_0000;
        endcase
        // Stores and faulted accesses always return zero data.
        if (req_write || acc_err) begin
            acc_rdata = 32'h0000_0000;
        end
    end

    // Commit store bytes to the array at the accept edge.
    // NOTE: the array has no reset branch on purpose: contents survive reset and the storage can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wlanes[8*b +: 8];
                end
            end
        end
    end

    // Request/response sequencing with all handshake outputs registered.
    // NOTE: state is updated with non-blocking assignments only, so every branch reads the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0000_0000;
            rsp_err    <= 1'b0;
            pend_rdata <= 32'h0000_0000;
            pend_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= acc_rdata;
                            rsp_err   <= acc_err;
                        end else begin
                            state      <= ST_WAIT;
                            cnt        <= CNT_W'(LATENCY - 1);
                            pend_rdata <= acc_rdata;
                            pend_err   <= acc_err;
                        end
                    end
                end
                ST_WAIT: begin
                    req_ready <= 1'b0;
                    if (cnt == '0) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pend_rdata;
                        rsp_err   <= pend_err;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Hold the response stable until the consumer takes it.
                    req_ready <= 1'b0;
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0000_0000;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table plus hand-written sequences for
// backpressure and reset in the middle of an access (LATENCY=2, 1024 words).
module tb_mem_responder;

    localparam int LAT = 2;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[22];

    mem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_funct3(req_funct3),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence wedges despite its local bounds.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accept edge until rsp_valid shows, bounded.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // Full transaction: present, wait for accept, scramble inputs, wait for
    // the response, check it, then take it and check the return to IDLE.
    task automatic run_txn(input vec_t v, input int idx);
        int waited;
        int lat;
        req_valid  = 1'b1;
        req_write  = v.write;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_funct3 = v.f3;
        waited     = 0;
        while (!req_ready && waited < 20) begin
            step();
            waited++;
        end
        check($sformatf("vec%0d_ready_seen", idx), {31'd0, req_ready}, 32'd1);
        step();
        req_valid  = 1'b0;
        req_write  = ~v.write;
        req_addr   = ~v.addr;
        req_wdata  = ~v.wdata;
        req_funct3 = 3'b111;
        wait_rsp(lat);
        check($sformatf("vec%0d_latency", idx), lat, LAT);
        check($sformatf("vec%0d_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("vec%0d_err", idx), {31'd0, rsp_err}, {31'd0, v.exp_err});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check($sformatf("vec%0d_rsp_drop", idx), {31'd0, rsp_valid}, 32'd0);
        check($sformatf("vec%0d_idle_ready", idx), {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic seen;

        // {write, addr, wdata, funct3, expected rdata, expected err}
        vecs[0]  = '{1'b1, 32'h10,   32'hDEAD_BEEF, F_W,  32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,         F_W,  32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,   32'h0,         F_W,  32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'h13,   32'h0000_00F0, F_B,  32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h10,   32'h0,         F_W,  32'hF000_0000, 1'b0};
        vecs[5]  = '{1'b0, 32'h13,   32'h0,         F_B,  32'hFFFF_FFF0, 1'b0};
        vecs[6]  = '{1'b0, 32'h13,   32'h0,         F_BU, 32'h0000_00F0, 1'b0};
        vecs[7]  = '{1'b1, 32'h12,   32'h0000_8001, F_H,  32'h0,         1'b0};
        vecs[8]  = '{1'b0, 32'h12,   32'h0,         F_H,  32'hFFFF_8001, 1'b0};
        vecs[9]  = '{1'b0, 32'h12,   32'h0,         F_HU, 32'h0000_8001, 1'b0};
        vecs[10] = '{1'b0, 32'h11,   32'h0,         F_W,  32'h0,         1'b1};
        vecs[11] = '{1'b1, 32'h11,   32'h0000_FFFF, F_H,  32'h0,         1'b1};
        vecs[12] = '{1'b0, 32'h10,   32'h0,         F_W,  32'h8001_0000, 1'b0};
        vecs[13] = '{1'b1, 32'h1000, 32'h1234_5678, F_W,  32'h0,         1'b0};
        vecs[14] = '{1'b0, 32'h0,    32'h0,         F_W,  32'h1234_5678, 1'b0};
        vecs[15] = '{1'b0, 32'h0,    32'h0,         3'b011, 32'h0,       1'b1};
        vecs[16] = '{1'b1, 32'h0,    32'h0000_00AA, F_BU, 32'h0,         1'b1};
        vecs[17] = '{1'b0, 32'h1000, 32'h0,         F_W,  32'h1234_5678, 1'b0};
        vecs[18] = '{1'b0, 32'h1,    32'h0,         F_B,  32'h0000_0056, 1'b0};
        vecs[19] = '{1'b0, 32'h2,    32'h0,         F_H,  32'h0000_1234, 1'b0};
        vecs[20] = '{1'b1, 32'h5,    32'h0000_007F, F_B,  32'h0,         1'b0};
        vecs[21] = '{1'b0, 32'h5,    32'h0,         F_BU, 32'h0000_007F, 1'b0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = F_W;
        rsp_ready  = 1'b0;

        // Reset state.
        step();
        step();
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 22; i++) begin
            run_txn(vecs[i], i);
        end

        // Backpressure: lw 0x10 held unread for several cycles while a
        // second request (lw 0x0) waits with req_valid high.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h10;
        req_funct3 = F_W;
        step();
        req_addr = 32'h0;
        wait_rsp(lat);
        check("bp_latency", lat, LAT);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("bp_hold%0d_rdata", i), rsp_rdata, 32'h8001_0000);
            check($sformatf("bp_hold%0d_ready", i), {31'd0, req_ready}, 32'd0);
            step();
        end
        check("bp_hold5_rdata", rsp_rdata, 32'h8001_0000);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_after_hs_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_after_hs_ready", {31'd0, req_ready}, 32'd1);
        step();
        check("bp_second_taken", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        wait_rsp(lat);
        check("bp_second_latency", lat, LAT);
        check("bp_second_rdata", rsp_rdata, 32'h1234_5678);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset during WAIT: store first, then abort a load mid-flight.
        run_txn('{1'b1, 32'h20, 32'hCAFE_F00D, F_W, 32'h0, 1'b0}, 100);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h20;
        req_funct3 = F_W;
        step();
        req_valid = 1'b0;
        check("mid_wait_busy", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        step();
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        step();
        check("mid_post_rst_ready", {31'd0, req_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | rsp_valid;
            step();
        end
        check("mid_no_rsp", {31'd0, seen}, 32'd0);
        run_txn('{1'b0, 32'h20, 32'h0, F_W, 32'hCAFE_F00D, 1'b0}, 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
